// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM bulk loader: FSM state encoding and default sizes.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2
  } state_e;

  localparam int KB_DEFAULT = 16;
  localparam int DW_DEFAULT = 8;

  // The loader owns the RAM port in every state except idle.
  function automatic logic owns_ram(input state_e s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/ram_loader.sv
// Bulk-load master: streams bytes into consecutive RAM addresses from a base,
// reads the region back, and compares the readback sum against the write sum.
// While idle the CPU port passes straight through to the RAM.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter  int KB = KB_DEFAULT,
  parameter  int DW = DW_DEFAULT,
  localparam int AW = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   length,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          cpu_ce,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_d,
  input  logic [AW-1:0] cpu_a,
  output logic [DW-1:0] cpu_q,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [DW-1:0] ram_d,
  output logic [AW-1:0] ram_a,
  input  logic [DW-1:0] ram_q,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] sum
);

  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  logic [AW:0]   acnt_q, acnt_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] vsum_q, vsum_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  // Events for this cycle; all of them require ce so a ce=0 cycle changes nothing.
  logic          start_go;
  logic          wr_fire;
  logic          rd_fire;
  logic          acc_fire;
  logic          last_acc;
  logic [DW-1:0] vsum_acc;

  assign start_go = (state_q == S_IDLE) && start && ce;
  assign wr_fire  = (state_q == S_LOAD) && ce && s_valid;
  assign rd_fire  = (state_q == S_VERIFY) && ce && (rcnt_q < len_q);
  assign acc_fire = (state_q == S_VERIFY) && ce && pend_q;
  assign last_acc = acc_fire && (acnt_q == (len_q - CNT_ONE));
  assign vsum_acc = vsum_q + ram_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a zero-length start never leaves idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_go && (length != '0)) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (wr_fire && ((wcnt_q + CNT_ONE) == len_q)) state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (last_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: latched operands, counters and checksums.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      acnt_q <= '0;
      sum_q  <= '0;
      vsum_q <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      acnt_q <= acnt_d;
      sum_q  <= sum_d;
      vsum_q <= vsum_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  // Datapath next values; pend marks that a read was issued on the previous ce cycle.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    acnt_d = acnt_q;
    sum_d  = sum_q;
    vsum_d = vsum_q;
    pend_d = pend_q;
    err_d  = err_q;
    // A pending zero-length done waits through ce=0 cycles and is shown on the next ce cycle.
    done_d = ce ? 1'b0 : done_q;

    if (start_go) begin
      base_d = base;
      len_d  = length;
      wcnt_d = '0;
      rcnt_d = '0;
      acnt_d = '0;
      sum_d  = '0;
      vsum_d = '0;
      pend_d = 1'b0;
      err_d  = 1'b0;
      done_d = (length == '0);
    end

    if (wr_fire) begin
      sum_d  = sum_q + s_data;
      wcnt_d = wcnt_q + CNT_ONE;
    end

    if ((state_q == S_VERIFY) && ce) begin
      pend_d = rd_fire;
    end

    if (rd_fire) begin
      rcnt_d = rcnt_q + CNT_ONE;
    end

    if (acc_fire) begin
      vsum_d = vsum_acc;
      acnt_d = acnt_q + CNT_ONE;
    end

    if (last_acc) begin
      err_d = (vsum_acc != sum_q);
    end
  end

  // Output logic: RAM port mux, stream handshake and status.
  always_comb begin
    ram_ce  = cpu_ce;
    ram_we  = cpu_we;
    ram_d   = cpu_d;
    ram_a   = cpu_a;
    s_ready = 1'b0;
    case (state_q)
      S_LOAD: begin
        s_ready = ce;
        ram_ce  = wr_fire;
        ram_we  = 1'b0;
        ram_d   = s_data;
        ram_a   = base_q + wcnt_q[AW-1:0];
      end
      S_VERIFY: begin
        ram_ce  = rd_fire;
        ram_we  = 1'b1;
        ram_d   = '0;
        ram_a   = base_q + rcnt_q[AW-1:0];
      end
      default: begin
        ram_ce  = cpu_ce;
        ram_we  = cpu_we;
        ram_d   = cpu_d;
        ram_a   = cpu_a;
      end
    endcase
    busy  = owns_ram(state_q);
    // The final accumulation resolves done/err in the same clock it happens.
    done  = (done_q && ce) || last_acc;
    err   = last_acc ? (vsum_acc != sum_q) : err_q;
    sum   = sum_q;
    cpu_q = ram_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader with a behavioural byte RAM on the ram_* port.
`timescale 1ns/1ps
module tb_ram_loader;

  localparam int KB = 16;
  localparam int DW = 8;
  localparam int AW = 14;
  localparam int N  = KB * 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          cpu_ce = 1'b0;
  logic          cpu_we = 1'b1;
  logic [DW-1:0] cpu_d = '0;
  logic [AW-1:0] cpu_a = '0;
  logic [DW-1:0] cpu_q;
  logic          ram_ce;
  logic          ram_we;
  logic [DW-1:0] ram_d;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_q = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] sum;

  ram_loader #(.KB(KB), .DW(DW)) dut (
    .clock(clock), .reset(reset), .ce(ce), .start(start),
    .base(base), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_d(cpu_d), .cpu_a(cpu_a), .cpu_q(cpu_q),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_d(ram_d), .ram_a(ram_a), .ram_q(ram_q),
    .busy(busy), .done(done), .err(err), .sum(sum)
  );

  always #5 clock = ~clock;

  // Byte RAM: registered read, active-low write, plus a bench backdoor write port.
  logic [DW-1:0] mem [N];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_a = '0;
  logic [DW-1:0] bd_d = '0;
  always @(posedge clock) begin
    if (ram_ce) begin
      if (!ram_we) mem[ram_a] <= ram_d;
      else         ram_q <= mem[ram_a];
    end
    if (bd_we) mem[bd_a] <= bd_d;
  end

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          base;
    int          len;
    logic [7:0]  sum;
    logic        err;
    longint      start_cyc;
    longint      done_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [N];
  logic [7:0] stim [64];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks the result against it.
  exp_t mon_e;
  int   mon_a;
  always @(negedge clock) begin
    if (!reset) begin
      chk("cpu_q_follows_ram_q", cpu_q, ram_q);
      if (busy) chk("ram_ce_only_on_ce", int'(ram_ce && !ce), 0);
      if (done) begin
        chk("done_only_on_ce", int'(ce), 1);
        chk("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sum", sum, mon_e.sum);
          chk("err", err, mon_e.err);
          if (mon_e.done_cyc >= 0)
            chk("done_latency", int'(cyc - mon_e.start_cyc), int'(mon_e.done_cyc));
          for (int i = 0; i < mon_e.len; i++) begin
            mon_a = (mon_e.base + i) % N;
            chk("ram_byte", mem[mon_a], ref_mem[mon_a]);
          end
          $display("done: base=0x%0h len=%0d sum=0x%0h err=%0d", mon_e.base, mon_e.len, sum, err);
        end
      end
    end
  end

  // One load operation. mode 0: ce and s_valid always high; mode 1: ce every 2nd clock,
  // random s_valid. abort_after >= 0 resets the DUT after that many bytes were accepted.
  task automatic run_op(input int b, input int len, input int mode, input bit corrupt,
                        input bit cpu_wr, input int abort_after);
    exp_t       e;
    int         idx;
    int         steps;
    bit         fire;
    logic [7:0] s;
    logic [7:0] vs;
    int         cpu_addr;
    logic [7:0] cpu_pre;
    s = 0;
    for (int i = 0; i < len; i++) s += stim[i];
    cpu_addr = (b + len + 100) % N;
    cpu_pre  = mem[cpu_addr];
    @(negedge clock);
    start   = 1'b1;
    base    = AW'(b);
    length  = (AW + 1)'(len);
    ce      = 1'b1;
    s_valid = 1'b0;
    if (abort_after < 0) begin
      for (int i = 0; i < len; i++) ref_mem[(b + i) % N] = stim[i];
      if (corrupt) ref_mem[b % N] = stim[0] ^ 8'hFF;
      vs = 0;
      for (int i = 0; i < len; i++) vs += ref_mem[(b + i) % N];
      e.base = b; e.len = len; e.sum = s; e.err = (vs != s);
      e.start_cyc = cyc;
      e.done_cyc  = (mode == 0) ? longint'(2 * len + 1) : -1;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    if (len == 0) begin
      chk("zero_len_busy", busy, 0);
      chk("zero_len_ram_ce", ram_ce, 0);
    end
    idx = 0;
    steps = 0;
    while (idx < len && steps < 4000) begin
      if (idx == abort_after) begin
        reset = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("abort_s_ready", s_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_sum", sum, 0);
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_a = 14'h123; cpu_d = 8'h5A;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("pass_ram_ce", ram_ce, 1);
        chk("pass_ram_we", ram_we, 1);
        chk("pass_ram_a", ram_a, 'h123);
        chk("pass_ram_d", ram_d, 'h5A);
        $display("abort: base=0x%0h after %0d bytes", b, idx);
        cpu_ce = 1'b0;
        return;
      end
      ce      = (mode == 0) ? 1'b1 : cyc[0];
      s_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_data  = stim[idx];
      bd_we   = corrupt && (idx == 1);
      bd_a    = AW'(b % N);
      bd_d    = stim[0] ^ 8'hFF;
      #1;
      fire   = s_valid && s_ready;
      cpu_ce = cpu_wr && busy;
      cpu_we = !(cpu_wr && busy);
      cpu_a  = AW'(cpu_addr);
      cpu_d  = 8'hC3;
      @(negedge clock);
      if (fire) idx++;
      steps++;
    end
    bd_we   = 1'b0;
    s_valid = 1'b0;
    while (sb.size() > 0 && steps < 4000) begin
      ce = (mode == 0) ? 1'b1 : cyc[0];
      #1;
      cpu_ce = cpu_wr && busy;
      cpu_we = !(cpu_wr && busy);
      @(negedge clock);
      steps++;
    end
    chk("op_completed", sb.size(), 0);
    sb.delete();
    cpu_ce = 1'b0;
    cpu_we = 1'b1;
    ce     = 1'b1;
    if (cpu_wr) chk("cpu_write_dropped", mem[cpu_addr], cpu_pre);
  endtask

  initial begin
    int b;
    int len;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_sum", sum, 0);
    @(negedge clock);
    reset = 1'b0;

    // Four known bytes, full rate.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    run_op('h100, 4, 0, 1'b0, 1'b0, -1);
    chk("t2_sum", sum, 'hAA);
    chk("t2_err", err, 0);

    // Reset in the middle of a load.
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
    run_op('h200, 8, 0, 1'b0, 1'b0, 3);

    // Address wrap at the top of the RAM.
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom_range(0, 255));
    run_op('h3FFE, 4, 0, 1'b0, 1'b0, -1);
    chk("t3_err", err, 0);

    // Throttled ce and ragged s_valid.
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
    run_op(int'($urandom_range(0, N - 1)), 8, 1, 1'b0, 1'b0, -1);

    // Zero length.
    run_op('h50, 0, 0, 1'b0, 1'b0, -1);

    // Corrupted cell plus a CPU write attempt while busy.
    for (int i = 0; i < 6; i++) stim[i] = 8'($urandom_range(0, 255));
    run_op('h500, 6, 0, 1'b1, 1'b1, -1);
    chk("t6_err", err, 1);

    // Random operations.
    for (int k = 0; k < 8; k++) begin
      b   = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) stim[i] = 8'($urandom_range(0, 255));
      run_op(b, len, int'($urandom_range(0, 1)), (len >= 2) && ($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)), -1);
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
